// File: rtl/mdio_slave_mmd_pkg.sv
// Shared definitions for the Clause 45 MDIO responder: opcodes, FSM state
// encoding, preamble length and a helper giving the last bit index per state.
package mdio_defs;

  localparam logic [1:0] OP_ADDR  = 2'b00;
  localparam logic [1:0] OP_WR    = 2'b01;
  localparam logic [1:0] OP_RDINC = 2'b10;
  localparam logic [1:0] OP_RD    = 2'b11;

  localparam logic [5:0] PREAMBLE_LEN = 6'd32;

  typedef enum logic [2:0] {
    ST_PREAMBLE = 3'd0,
    ST_START    = 3'd1,
    ST_OP       = 3'd2,
    ST_PRT      = 3'd3,
    ST_DEV      = 3'd4,
    ST_TA       = 3'd5,
    ST_DATA     = 3'd6
  } mdio_state_e;

  // Index of the final bit of each frame field (bit counter starts at 0).
  function automatic logic [5:0] last_bit(input mdio_state_e st);
    case (st)
      ST_OP:   last_bit = 6'd1;
      ST_PRT:  last_bit = 6'd4;
      ST_DEV:  last_bit = 6'd4;
      ST_TA:   last_bit = 6'd1;
      ST_DATA: last_bit = 6'd15;
      default: last_bit = 6'd0;
    endcase
  endfunction

  // Both read opcodes have the MSB set.
  function automatic logic is_read(input logic [1:0] op);
    is_read = op[1];
  endfunction

endpackage

// File: rtl/mdio_slave_mmd_if.sv
// Register-bank port of the MDIO responder.
//   master : the MDIO responder (drives address, strobes and write data)
//   slave  : the local register bank (returns read data the cycle after reg_rd)
interface mdio_slave_mmd_if;
  logic [4:0]  reg_devad;
  logic [15:0] reg_addr;
  logic        reg_wr;
  logic [15:0] reg_wr_data;
  logic        reg_rd;
  logic [15:0] reg_rd_data;

  modport master (
    output reg_devad, reg_addr, reg_wr, reg_wr_data, reg_rd,
    input  reg_rd_data
  );

  modport slave (
    input  reg_devad, reg_addr, reg_wr, reg_wr_data, reg_rd,
    output reg_rd_data
  );
endinterface

// File: rtl/mdio_slave_mmd_edge_sync.sv
// Two-flop synchronizers for mdc and mdio_i plus rising-edge detect of mdc.
// Ports: clk, reset (async active-low), mdc, mdio_i in;
//        mdc_rise (one-cycle pulse), mdio_s (synced line, aligned with mdc_rise) out.
module mdio_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic mdc,
  input  logic mdio_i,
  output logic mdc_rise,
  output logic mdio_s
);

  logic [2:0] mdc_q_r;
  logic [1:0] mdio_q_r;

  // Synchronizer chains; idle-high so a reset never fakes an mdc edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mdc_q_r  <= 3'b111;
      mdio_q_r <= 2'b11;
    end else begin
      mdc_q_r  <= {mdc_q_r[1:0], mdc};
      mdio_q_r <= {mdio_q_r[0], mdio_i};
    end
  end

  assign mdc_rise = mdc_q_r[1] & ~mdc_q_r[2];
  assign mdio_s   = mdio_q_r[1];

endmodule

// File: rtl/mdio_slave_mmd.sv
// Clause 45 MDIO responder (MMD side).
// Ports: mgmt_clk, reset (async active-low), mdc, mdio_i in;
//        mdio_o / mdio_t out (IOBUF style, mdio_t=1 releases the line);
//        reg_bus (master modport) towards the local register bank.
// Line drive is registered off mdc_rise, so each driven bit is stable at the
// master's next rising mdc edge: the 0 issued after TA bit 1 is seen at TA bit 2.
module mdio_slave_mmd
  import mdio_defs::*;
#(
  parameter logic [4:0]  PRTAD      = 5'd0,
  parameter logic [31:0] DEVAD_MASK = 32'h0000_0002
) (
  input  logic               mgmt_clk,
  input  logic               reset,
  input  logic               mdc,
  input  logic               mdio_i,
  output logic               mdio_o,
  output logic               mdio_t,
  mdio_slave_mmd_if.master   reg_bus
);

  logic        mdc_rise_s;
  logic        mdio_bit_s;
  mdio_state_e state_r, state_nxt_s;
  logic [5:0]  cnt_r;
  logic [1:0]  op_r;
  logic [4:0]  prt_r;
  logic [4:0]  dev_r;
  logic [15:0] shift_r;
  logic        rd_lat_r;
  logic        last_s;
  logic        sel_s;
  logic [15:0] frame_data_s;
  logic        mdio_o_nxt_s, mdio_t_nxt_s, rd_nxt_s, wr_nxt_s;
  logic [15:0] addr_nxt_s, wr_data_nxt_s;
  logic [4:0]  devad_nxt_s;

  mdio_edge_sync u_sync (
    .clk      (mgmt_clk),
    .reset    (reset),
    .mdc      (mdc),
    .mdio_i   (mdio_i),
    .mdc_rise (mdc_rise_s),
    .mdio_s   (mdio_bit_s)
  );

  assign last_s       = (cnt_r == last_bit(state_r));
  assign sel_s        = (prt_r == PRTAD) && DEVAD_MASK[{dev_r[3:0], mdio_bit_s}];
  assign frame_data_s = {shift_r[14:0], mdio_bit_s};

  // FSM state register.
  always_ff @(posedge mgmt_clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_PREAMBLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode, advanced only on mdc_rise.
  always_comb begin
    state_nxt_s = state_r;
    if (mdc_rise_s) begin
      case (state_r)
        ST_PREAMBLE: begin
          if (!mdio_bit_s && (cnt_r == PREAMBLE_LEN)) state_nxt_s = ST_START;
          else                                         state_nxt_s = ST_PREAMBLE;
        end
        ST_START: state_nxt_s = mdio_bit_s ? ST_PREAMBLE : ST_OP;
        ST_OP:    state_nxt_s = last_s ? ST_PRT : ST_OP;
        ST_PRT:   state_nxt_s = last_s ? ST_DEV : ST_PRT;
        ST_DEV: begin
          if (!last_s)    state_nxt_s = ST_DEV;
          else if (sel_s) state_nxt_s = ST_TA;
          else            state_nxt_s = ST_PREAMBLE;
        end
        ST_TA:    state_nxt_s = last_s ? ST_DATA : ST_TA;
        ST_DATA:  state_nxt_s = last_s ? ST_PREAMBLE : ST_DATA;
        default:  state_nxt_s = ST_PREAMBLE;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Output decode: next values of line drive, strobes and register-port fields.
  always_comb begin
    mdio_o_nxt_s  = mdio_o;
    mdio_t_nxt_s  = mdio_t;
    rd_nxt_s      = 1'b0;
    wr_nxt_s      = 1'b0;
    addr_nxt_s    = reg_bus.reg_addr;
    devad_nxt_s   = reg_bus.reg_devad;
    wr_data_nxt_s = reg_bus.reg_wr_data;
    if (mdc_rise_s) begin
      // Line is released unless a read below claims it.
      mdio_o_nxt_s = 1'b1;
      mdio_t_nxt_s = 1'b1;
      case (state_r)
        ST_TA: begin
          if (is_read(op_r) && !last_s) begin
            mdio_o_nxt_s = 1'b0;
            mdio_t_nxt_s = 1'b0;
            rd_nxt_s     = 1'b1;
            devad_nxt_s  = dev_r;
          end else if (is_read(op_r)) begin
            mdio_o_nxt_s = shift_r[15];
            mdio_t_nxt_s = 1'b0;
          end else begin
            mdio_t_nxt_s = 1'b1;
          end
        end
        ST_DATA: begin
          if (is_read(op_r) && !last_s) begin
            mdio_o_nxt_s = shift_r[15];
            mdio_t_nxt_s = 1'b0;
          end else if (last_s) begin
            case (op_r)
              OP_ADDR: begin
                addr_nxt_s  = frame_data_s;
                devad_nxt_s = dev_r;
              end
              OP_WR: begin
                wr_data_nxt_s = frame_data_s;
                devad_nxt_s   = dev_r;
                wr_nxt_s      = 1'b1;
              end
              OP_RDINC: addr_nxt_s = reg_bus.reg_addr + 16'd1;
              default:  addr_nxt_s = reg_bus.reg_addr;
            endcase
          end else begin
            mdio_t_nxt_s = 1'b1;
          end
        end
        default: mdio_t_nxt_s = 1'b1;
      endcase
    end else begin
      rd_nxt_s = 1'b0;
    end
  end

  // Registered outputs towards the line and the register bank.
  always_ff @(posedge mgmt_clk or negedge reset) begin
    if (!reset) begin
      mdio_o              <= 1'b1;
      mdio_t              <= 1'b1;
      reg_bus.reg_rd      <= 1'b0;
      reg_bus.reg_wr      <= 1'b0;
      reg_bus.reg_addr    <= 16'h0000;
      reg_bus.reg_devad   <= 5'd0;
      reg_bus.reg_wr_data <= 16'h0000;
    end else begin
      mdio_o              <= mdio_o_nxt_s;
      mdio_t              <= mdio_t_nxt_s;
      reg_bus.reg_rd      <= rd_nxt_s;
      reg_bus.reg_wr      <= wr_nxt_s;
      reg_bus.reg_addr    <= addr_nxt_s;
      reg_bus.reg_devad   <= devad_nxt_s;
      reg_bus.reg_wr_data <= wr_data_nxt_s;
    end
  end

  // Frame datapath: bit counter, header fields and the shared data shifter.
  always_ff @(posedge mgmt_clk or negedge reset) begin
    if (!reset) begin
      cnt_r    <= 6'd0;
      op_r     <= 2'b00;
      prt_r    <= 5'd0;
      dev_r    <= 5'd0;
      shift_r  <= 16'h0000;
      rd_lat_r <= 1'b0;
    end else begin
      // Bank data is valid the cycle after reg_rd; load it then.
      rd_lat_r <= reg_bus.reg_rd;
      if (rd_lat_r) begin
        shift_r <= reg_bus.reg_rd_data;
      end else if (mdc_rise_s && ((state_r == ST_DATA) || ((state_r == ST_TA) && last_s))) begin
        shift_r <= frame_data_s;
      end else begin
        shift_r <= shift_r;
      end
      if (mdc_rise_s) begin
        if (state_r == ST_PREAMBLE) begin
          if (!mdio_bit_s)                 cnt_r <= 6'd0;
          else if (cnt_r == PREAMBLE_LEN)  cnt_r <= cnt_r;
          else                             cnt_r <= cnt_r + 6'd1;
        end else if (last_s) begin
          cnt_r <= 6'd0;
        end else begin
          cnt_r <= cnt_r + 6'd1;
        end
        op_r  <= (state_r == ST_OP)  ? {op_r[0], mdio_bit_s}     : op_r;
        prt_r <= (state_r == ST_PRT) ? {prt_r[3:0], mdio_bit_s}  : prt_r;
        dev_r <= (state_r == ST_DEV) ? {dev_r[3:0], mdio_bit_s}  : dev_r;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_mdio_slave_mmd.sv
// Directed bench for mdio_slave_mmd: acts as MDIO master and register bank.
module tb_mdio_slave_mmd;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic mdc = 1'b0;
  logic mdio_i = 1'b1;
  logic mdio_o, mdio_t;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int t_low_cnt = 0;
  logic [15:0] last_wr_data = 16'h0000;
  logic [15:0] last_wr_addr = 16'h0000;
  logic [15:0] last_rd_addr = 16'h0000;
  logic [16:0] rx;
  logic [1:0]  ta;
  logic        smp, smp_t;
  int          wr_before, rd_before, tlow_before;

  mdio_slave_mmd_if bus ();

  mdio_slave_mmd dut (
    .mgmt_clk (clk),
    .reset    (reset),
    .mdc      (mdc),
    .mdio_i   (mdio_i),
    .mdio_o   (mdio_o),
    .mdio_t   (mdio_t),
    .reg_bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] bank(input logic [15:0] a);
    case (a)
      16'h0010: bank = 16'hA5C3;
      16'hFFFF: bank = 16'h1234;
      16'h0000: bank = 16'h5678;
      default:  bank = 16'hDEAD;
    endcase
  endfunction

  // Register bank model and strobe monitor.
  always @(posedge clk) begin
    if (bus.reg_wr) begin
      wr_cnt       <= wr_cnt + 1;
      last_wr_data <= bus.reg_wr_data;
      last_wr_addr <= bus.reg_addr;
    end
    if (bus.reg_rd) begin
      rd_cnt           <= rd_cnt + 1;
      last_rd_addr     <= bus.reg_addr;
      bus.reg_rd_data  <= bank(bus.reg_addr);
    end
    if (!mdio_t) t_low_cnt <= t_low_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One MDIO bit: present b during mdc low, sample line just before the rising edge.
  task automatic mdio_cycle(input logic b, output logic line, output logic t);
    @(negedge clk);
    mdio_i = b;
    repeat (5) @(negedge clk);
    line = mdio_t ? 1'b1 : mdio_o;
    t = mdio_t;
    mdc = 1'b1;
    repeat (6) @(negedge clk);
    mdc = 1'b0;
  endtask

  // pre ones, then the first nbits of body (ST OP PRT DEV TA DATA, MSB first).
  task automatic run_frame(input int pre, input logic [31:0] body, input int nbits,
                           output logic [16:0] rxv, output logic [1:0] tav);
    logic l, t;
    rxv = 17'h0;
    tav = 2'b00;
    for (int i = 0; i < pre; i++) mdio_cycle(1'b1, l, t);
    for (int i = 0; i < nbits; i++) begin
      mdio_cycle(body[31-i], l, t);
      if (i == 14) tav[1] = t;
      if (i == 15) begin tav[0] = t; rxv[16] = l; end
      if (i >= 16) rxv[31-i] = l;
    end
  endtask

  function automatic logic [31:0] wbody(input logic [1:0] st, input logic [1:0] op,
                                        input logic [4:0] prt, input logic [4:0] dev,
                                        input logic [15:0] d);
    wbody = {st, op, prt, dev, 2'b10, d};
  endfunction

  function automatic logic [31:0] rbody(input logic [1:0] op, input logic [4:0] prt,
                                        input logic [4:0] dev);
    rbody = {2'b00, op, prt, dev, 18'h3FFFF};
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    check("rst_mdio_t", {31'd0, mdio_t}, 32'd1);
    check("rst_mdio_o", {31'd0, mdio_o}, 32'd1);
    check("rst_reg_wr", {31'd0, bus.reg_wr}, 32'd0);
    check("rst_reg_rd", {31'd0, bus.reg_rd}, 32'd0);
    check("rst_reg_addr", {16'd0, bus.reg_addr}, 32'd0);
    check("rst_reg_devad", {27'd0, bus.reg_devad}, 32'd0);
    check("rst_reg_wr_data", {16'd0, bus.reg_wr_data}, 32'd0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Address then write.
    run_frame(32, wbody(2'b00, 2'b00, 5'd0, 5'd1, 16'h0010), 32, rx, ta);
    check("addr_reg_addr", {16'd0, bus.reg_addr}, 32'h0010);
    check("addr_reg_devad", {27'd0, bus.reg_devad}, 32'd1);
    check("addr_no_wr", wr_cnt, 32'd0);
    run_frame(32, wbody(2'b00, 2'b01, 5'd0, 5'd1, 16'hBEEF), 32, rx, ta);
    check("wr_pulse_count", wr_cnt, 32'd1);
    check("wr_data", {16'd0, last_wr_data}, 32'hBEEF);
    check("wr_addr", {16'd0, last_wr_addr}, 32'h0010);
    check("wr_devad", {27'd0, bus.reg_devad}, 32'd1);
    check("wr_addr_kept", {16'd0, bus.reg_addr}, 32'h0010);

    // Read.
    run_frame(32, rbody(2'b11, 5'd0, 5'd1), 32, rx, ta);
    check("rd_line", {15'd0, rx}, {15'd0, 1'b0, 16'hA5C3});
    check("rd_ta_t", {30'd0, ta}, 32'd2);
    check("rd_released", {31'd0, mdio_t}, 32'd1);
    check("rd_addr_kept", {16'd0, bus.reg_addr}, 32'h0010);
    check("rd_pulse_count", rd_cnt, 32'd1);
    check("rd_strobe_addr", {16'd0, last_rd_addr}, 32'h0010);

    // Read-post-increment wrap.
    run_frame(32, wbody(2'b00, 2'b00, 5'd0, 5'd1, 16'hFFFF), 32, rx, ta);
    check("inc_setup_addr", {16'd0, bus.reg_addr}, 32'hFFFF);
    run_frame(32, rbody(2'b10, 5'd0, 5'd1), 32, rx, ta);
    check("inc1_data", {16'd0, rx[15:0]}, 32'h1234);
    check("inc1_addr", {16'd0, bus.reg_addr}, 32'h0000);
    run_frame(32, rbody(2'b10, 5'd0, 5'd1), 32, rx, ta);
    check("inc2_data", {16'd0, rx[15:0]}, 32'h5678);
    check("inc2_addr", {16'd0, bus.reg_addr}, 32'h0001);
    check("inc_rd_pulses", rd_cnt, 32'd3);

    // Filtering: wrong port, unmasked DEVAD, Clause 22 start.
    wr_before = wr_cnt; rd_before = rd_cnt; tlow_before = t_low_cnt;
    run_frame(32, rbody(2'b11, 5'd1, 5'd1), 32, rx, ta);
    check("prt_no_rd", rd_cnt, rd_before);
    check("prt_line_idle", t_low_cnt, tlow_before);
    run_frame(32, rbody(2'b11, 5'd0, 5'd3), 32, rx, ta);
    check("dev3_no_rd", rd_cnt, rd_before);
    check("dev3_line_idle", t_low_cnt, tlow_before);
    run_frame(32, wbody(2'b01, 2'b01, 5'd0, 5'd1, 16'h7777), 32, rx, ta);
    check("st01_no_wr", wr_cnt, wr_before);

    // Short preamble rejected, full preamble accepted.
    mdio_cycle(1'b0, smp, smp_t);
    run_frame(31, wbody(2'b00, 2'b01, 5'd0, 5'd1, 16'h1111), 32, rx, ta);
    check("short_pre_no_wr", wr_cnt, wr_before);
    run_frame(32, wbody(2'b00, 2'b01, 5'd0, 5'd1, 16'h1111), 32, rx, ta);
    check("full_pre_wr", wr_cnt, wr_before + 1);
    check("full_pre_data", {16'd0, last_wr_data}, 32'h1111);
    check("full_pre_addr", {16'd0, last_wr_addr}, 32'h0001);

    // Reset during data bit 7 of a read.
    run_frame(32, rbody(2'b11, 5'd0, 5'd1), 23, rx, ta);
    @(negedge clk);
    mdio_i = 1'b1;
    repeat (5) @(negedge clk);
    mdc = 1'b1;
    repeat (4) @(negedge clk);
    check("mid_read_driving", {31'd0, mdio_t}, 32'd0);
    reset = 1'b0;
    #1;
    check("mid_read_release_t", {31'd0, mdio_t}, 32'd1);
    check("mid_read_release_o", {31'd0, mdio_o}, 32'd1);
    repeat (2) @(negedge clk);
    mdc = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_read_addr_cleared", {16'd0, bus.reg_addr}, 32'd0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    rd_before = rd_cnt;
    run_frame(32, rbody(2'b11, 5'd0, 5'd1), 32, rx, ta);
    check("post_rst_rd_line", {15'd0, rx}, {15'd0, 1'b0, 16'h5678});
    check("post_rst_rd_pulse", rd_cnt, rd_before + 1);
    check("post_rst_released", {31'd0, mdio_t}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
